// File: rtl/spook_msk_pkg.sv
// Shared constants and helpers for the masked Spook datapath.
// Beat/slot sizing functions and the column loader FSM encoding.
package spook_msk_pkg;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // bits per input beat: CPB columns of d shared nibbles
  function automatic int bw_f(input int d, input int cpb);
    return 4 * d * cpb;
  endfunction

  // beats needed to assemble one full state
  function automatic int nb_f(input int nbits, input int cpb);
    return nbits / (4 * cpb);
  endfunction

  // beat counter width, never below one bit
  function automatic int cnt_w_f(input int nb);
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/cols_loader.sv
// Collects CPB-column shared beats into a full column-form state.
// Define COLS_LOADER_ZEROIZE_EN to wipe shares on take and on clear.
module cols_loader
  import spook_msk_pkg::*;
#(
  parameter int d     = 1,
  parameter int Nbits = 128,
  parameter int CPB   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [4*d*CPB-1:0]      in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [Nbits*d-1:0]      cols_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int BW    = bw_f(d, CPB);
  localparam int NB    = nb_f(Nbits, CPB);
  localparam int CNT_W = cnt_w_f(NB);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             in_hs;
  logic             out_hs;
  logic             last;

  assign in_ready  = (state == ST_FILL) & rst_n;
  assign out_valid = (state == ST_FULL);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last      = (cnt == CNT_W'(NB - 1));

  // fill/full sequencing and beat slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      cnt   <= '0;
    end else if (clear) begin
      state <= ST_FILL;
      cnt   <= '0;
    end else if (in_hs) begin
      if (last) begin
        state <= ST_FULL;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (out_hs) begin
      state <= ST_FILL;
    end
  end

  // slot-wise write of accepted beats into the column state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_out <= '0;
    end else if (clear) begin
`ifdef COLS_LOADER_ZEROIZE_EN
      cols_out <= '0;
`else
      cols_out <= cols_out;
`endif
    end else if (in_hs) begin
      for (int k = 0; k < NB; k++) begin
        if (cnt == CNT_W'(k)) begin
          cols_out[k*BW +: BW] <= in_data;
        end
      end
    end else if (out_hs) begin
`ifdef COLS_LOADER_ZEROIZE_EN
      cols_out <= '0;
`else
      cols_out <= cols_out;
`endif
    end
  end

endmodule

// File: tb/tb_cols_loader.sv
// Directed scoreboard bench for cols_loader (d=2, Nbits=128, CPB=4).
// Follows COLS_LOADER_ZEROIZE_EN to pick the expected post-take state.
module tb_cols_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] cols_out;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  logic [255:0] mstate;
  int           mcnt;
  logic [255:0] sb[$];

  cols_loader #(.d(2), .Nbits(128), .CPB(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cols_out  (cols_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [31:0] v);
    mstate[mcnt*32 +: 32] = v;
    mcnt++;
    if (mcnt == 8) begin
      sb.push_back(mstate);
      mcnt = 0;
    end
  endtask

  task automatic beat(input logic [31:0] v);
    chk("in_ready_fill", in_ready, 1);
    chk("no_early_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data  = v;
    model_beat(v);
    @(negedge clk);
    chk("cols_track", cols_out, mstate);
  endtask

  task automatic expect_full();
    in_valid = 1'b0;
    chk("out_valid_rise", out_valid, 1);
    chk("in_ready_full", in_ready, 0);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) chk("sb_cols", cols_out, sb.pop_front());
  endtask

  task automatic load8(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          @(negedge clk);
          chk("gap_hold", cols_out, mstate);
        end
      end
      beat({4{base + 8'(i)}});
    end
    expect_full();
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`ifdef COLS_LOADER_ZEROIZE_EN
    mstate = '0;
`endif
    chk("take_out_valid", out_valid, 0);
    chk("take_in_ready", in_ready, 1);
    chk("cols_after_take", cols_out, mstate);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mstate    = '0;
    mcnt      = 0;

    repeat (2) @(negedge clk);
    chk("rst_cols", cols_out, '0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back load, then hold in FULL for 5 cycles
    load8(8'h00, 1'b0);
    chk("slot0", cols_out[0 +: 32], 32'h00000000);
    chk("slot3", cols_out[96 +: 32], 32'h03030303);
    chk("slot7", cols_out[224 +: 32], 32'h07070707);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_cols", cols_out, mstate);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take();

    // same data with random in_valid gaps
    load8(8'h00, 1'b1);
    take();
    load8(8'h10, 1'b1);
    take();

    // clear after three beats
    for (int i = 0; i < 3; i++) beat({4{8'h20 + 8'(i)}});
    in_valid = 1'b0;
    clear    = 1'b1;
    mcnt     = 0;
`ifdef COLS_LOADER_ZEROIZE_EN
    mstate = '0;
`endif
    @(negedge clk);
    clear = 1'b0;
    chk("clear_cols", cols_out, mstate);
    chk("clear_out_valid", out_valid, 0);
    load8(8'h30, 1'b0);
    chk("clear_slot0", cols_out[0 +: 32], 32'h30303030);
    take();

    // async reset mid-load
    for (int i = 0; i < 5; i++) beat({4{8'h40 + 8'(i)}});
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mstate = '0;
    mcnt   = 0;
    chk("arst_cols", cols_out, '0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load8(8'h50, 1'b1);
    chk("arst_slot0", cols_out[0 +: 32], 32'h50505050);
    take();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
